// File: rtl/hex_display_bank.sv
// Registered driver for a bank of active-low seven-segment digits with parallel load, digit
// shifting, leading-zero blanking and per-digit blinking.
module hex_display_bank #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic                    shift_en,
    input  logic [3:0]              shift_nib,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic [NUM_DIGITS-1:0]   punto,
    output logic                    blink_phase
);

    localparam int unsigned CntW = $clog2(BLINK_DIV) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [CntW-1:0]         cnt_q;
    logic                    blink_phase_q;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   punto_q, punto_d;

    // Active-high {g..a}.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Load beats shift when both strobes arrive together.
    always_comb begin
        value_d = value_q;
        dp_d    = dp_q;
        if (wr_en) begin
            value_d = wr_data;
            dp_d    = wr_dp;
        end else if (shift_en) begin
            value_d      = value_q << 4;
            value_d[3:0] = shift_nib;
            dp_d         = dp_q << 1;
        end
    end

    always_comb begin
        logic zero_run;
        logic [3:0] nib;
        seg_d    = '1;
        punto_d  = '1;
        zero_run = 1'b1;
        // Walk from the top digit down so zero_run means "this digit and all above are 0".
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            nib      = value_q[4*i +: 4];
            zero_run = zero_run && (nib == 4'h0);
            if (lz_blank && zero_run && (i != 0)) begin
                seg_d[7*i +: 7] = 7'h7F;
            end else begin
                seg_d[7*i +: 7] = ~decode(nib);
            end
            punto_d[i] = ~dp_q[i];
            if (blink_phase_q && blink_mask[i]) begin
                seg_d[7*i +: 7] = 7'h7F;
                punto_d[i]      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q       <= '0;
            dp_q          <= '0;
            cnt_q         <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= '1;
            punto_q       <= '1;
        end else begin
            value_q <= value_d;
            dp_q    <= dp_d;
            seg_q   <= seg_d;
            punto_q <= punto_d;
            if (cnt_q == CntMax) begin
                cnt_q         <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign seg         = seg_q;
    assign punto       = punto_q;
    assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed, table-driven bench for hex_display_bank (8 digits, blink half-period of 4 cycles).
module tb_hex_display_bank;

    localparam int ND = 8;
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [31:0]   wr_data;
    logic [7:0]    wr_dp;
    logic          shift_en;
    logic [3:0]    shift_nib;
    logic          lz_blank;
    logic [7:0]    blink_mask;
    logic [55:0]   seg;
    logic [7:0]    punto;
    logic          blink_phase;

    int checks   = 0;
    int failures = 0;

    hex_display_bank #(
        .NUM_DIGITS(ND),
        .BLINK_DIV (BD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .shift_en   (shift_en),
        .shift_nib  (shift_nib),
        .lz_blank   (lz_blank),
        .blink_mask (blink_mask),
        .seg        (seg),
        .punto      (punto),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic        lz;
        logic [55:0] seg;
        logic [7:0]  punto;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [55:0] act, input logic [55:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Expected patterns are active-low, digit 7 leftmost.
        vecs[0] = '{32'h0123ABCD, 8'h10, 1'b1,
                    {7'h7F, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21}, 8'hEF};
        vecs[1] = '{32'h0123ABCD, 8'h10, 1'b0,
                    {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21}, 8'hEF};
        vecs[2] = '{32'h00000000, 8'h00, 1'b1, {{7{7'h7F}}, 7'h40}, 8'hFF};
        vecs[3] = '{32'h89EF4567, 8'h81, 1'b1,
                    {7'h00, 7'h10, 7'h06, 7'h0E, 7'h19, 7'h12, 7'h02, 7'h78}, 8'h7E};
        vecs[4] = '{32'h00500000, 8'h0F, 1'b1,
                    {7'h7F, 7'h7F, 7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'hF0};
        vecs[5] = '{32'h00000000, 8'hFF, 1'b0, {8{7'h40}}, 8'h00};
        vecs[6] = '{32'h10000000, 8'h00, 1'b1, {7'h79, {7{7'h40}}}, 8'hFF};
        vecs[7] = '{32'h0000000F, 8'h00, 1'b1, {{7{7'h7F}}, 7'h0E}, 8'hFF};

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_dp = '0; shift_en = 1'b0;
        shift_nib = '0; lz_blank = 1'b0; blink_mask = '0;

        // Reset: dark during reset, all "0" after.
        step();
        chk("reset_seg", seg, {56{1'b1}});
        chk("reset_punto", 56'(punto), 56'hFF);
        step();
        rst = 1'b0;
        step();
        chk("post_reset_seg", seg, {8{7'h40}});
        chk("post_reset_punto", 56'(punto), 56'hFF);

        // Parallel loads: visible two edges after wr_en.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = vecs[i].data; wr_dp = vecs[i].dp; lz_blank = vecs[i].lz;
            step();
            wr_en = 1'b0;
            step();
            chk($sformatf("load%0d_seg", i), seg, vecs[i].seg);
            chk($sformatf("load%0d_punto", i), 56'(punto), 56'(vecs[i].punto));
        end

        // Back-to-back shifts 1,2,3 from zero.
        wr_en = 1'b1; wr_data = '0; wr_dp = '0; lz_blank = 1'b1;
        step();
        wr_en = 1'b0; shift_en = 1'b1; shift_nib = 4'h1;
        step();
        shift_nib = 4'h2;
        step();
        shift_nib = 4'h3;
        step();
        shift_en = 1'b0;
        chk("shift_latency_seg", seg, {{6{7'h7F}}, 7'h79, 7'h24});
        step();
        chk("shift123_seg", seg, {{5{7'h7F}}, 7'h79, 7'h24, 7'h30});

        // Load wins over a simultaneous shift.
        wr_en = 1'b1; wr_data = '0;
        step();
        wr_en = 1'b0; shift_en = 1'b1; shift_nib = 4'h1;
        step();
        shift_nib = 4'h2;
        step();
        shift_nib = 4'h3; wr_en = 1'b1; wr_data = 32'hFFFFFFFF;
        step();
        shift_en = 1'b0; wr_en = 1'b0;
        step();
        chk("load_beats_shift_seg", seg, {8{7'h0E}});

        // Decimal points shift with digits; the top dp is discarded.
        wr_en = 1'b1; wr_data = '0; wr_dp = 8'h81;
        step();
        wr_en = 1'b0; shift_en = 1'b1; shift_nib = 4'h5;
        step();
        shift_en = 1'b0;
        step();
        chk("shift_dp_seg", seg, {{7{7'h7F}}, 7'h12});
        chk("shift_dp_punto", 56'(punto), 56'hFD);

        // Top digit is discarded on shift.
        wr_en = 1'b1; wr_data = 32'h9ABCDEF1; wr_dp = '0; lz_blank = 1'b0;
        step();
        wr_en = 1'b0; shift_en = 1'b1; shift_nib = 4'h2;
        step();
        shift_en = 1'b0;
        step();
        chk("shift_discard_seg", seg,
            {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h79, 7'h24});

        // Blink on digit 0 with dp, starting from a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0; wr_en = 1'b1; wr_data = 32'h00000005; wr_dp = 8'h01;
        blink_mask = 8'h01; lz_blank = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            logic off;
            step();
            wr_en = 1'b0;
            off = (n >= 2) && ((((n - 1) / 4) % 2) == 1);
            chk($sformatf("blink_phase_n%0d", n), 56'(blink_phase), 56'((n / 4) % 2));
            chk($sformatf("blink_others_n%0d", n), 56'(seg[55:7]), 56'({7{7'h40}}));
            if (n == 1) begin
                chk("blink_d0_n1", 56'(seg[6:0]), 56'h40);
                chk("blink_punto_n1", 56'(punto), 56'hFF);
            end else begin
                chk($sformatf("blink_d0_n%0d", n), 56'(seg[6:0]), off ? 56'h7F : 56'h12);
                chk($sformatf("blink_punto_n%0d", n), 56'(punto), off ? 56'hFF : 56'hFE);
            end
        end

        // Reset mid-blink: phase clears and the first toggle is BLINK_DIV edges later.
        begin
            bit found = 1'b0;
            for (int k = 0; k < 3 * BD && !found; k++) begin
                step();
                if (blink_phase) found = 1'b1;
            end
            chk("midblink_reach_phase1", 56'(found), 56'h1);
        end
        rst = 1'b1;
        step();
        chk("midblink_rst_phase", 56'(blink_phase), 56'h0);
        chk("midblink_rst_seg", seg, {56{1'b1}});
        rst = 1'b0;
        for (int n = 1; n <= BD; n++) begin
            step();
            chk($sformatf("midblink_toggle_n%0d", n), 56'(blink_phase), 56'(n == BD));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_display_bank.md
# hex_display_bank

Parametrised, registered driver for a bank of active-low seven-segment displays on the DE2-70 board. It holds a NUM_DIGITS-nibble display value and a decimal-point mask, loaded in parallel or shifted in one digit at a time. It adds optional leading-zero blanking and per-digit blinking from an internal timebase. It sits between user logic (switch/counter datapaths) and the HEX0..HEX7 board pins.

## Interface
- NUM_DIGITS, 8: number of digits driven; legal range 1..8.
- BLINK_DIV, 25_000_000: clock cycles per blink half-period; must be ≥1. Simulation uses 4.
- clk  in  1  system clock (50 MHz board clock).
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  parallel load strobe; samples wr_data and wr_dp.
- wr_data  in  4*NUM_DIGITS  display value; digit i = wr_data[4i+3:4i], and digit 0 is rightmost.
- wr_dp  in  NUM_DIGITS  decimal-point enables, active-high, one per digit.
- shift_en  in  1  shift strobe; digits move up one place, shift_nib enters digit 0, and the top digit is discarded.
- shift_nib  in  4  nibble shifted into digit 0.
- lz_blank  in  1  when 1, leading zero digits are blanked.
- blink_mask  in  NUM_DIGITS  per-digit blink enable.
- seg  out  7*NUM_DIGITS  segments, active-low; digit i = seg[7i+6:7i], bit 0 = a … bit 6 = g.
- punto  out  NUM_DIGITS  decimal points, active-low.
- blink_phase  out  1  current blink phase; 1 = blinking digits are off.

## Operation
- State:
  - value_q: 4*NUM_DIGITS bits.
  - dp_q: NUM_DIGITS bits.
  - blink counter: width $clog2(BLINK_DIV)+1.
  - blink_phase.
  - Output registers seg and punto.
- Update priority per cycle: rst > wr_en > shift_en.
  - With wr_en and shift_en both high, the load wins and the shift is dropped.
  - A shift moves dp_q up with the digits; dp_q[0] becomes 0.
- Decoding (active-high {g..a}, inverted at output):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Leading-zero blanking:
  - Applies when lz_blank=1.
  - Digit i (i≥1) is blanked (seg all 1) when it and every digit above it are 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Decimal points are not affected by this rule.
- Blink:
  - The counter counts 0..BLINK_DIV-1. At terminal count it wraps to 0 and toggles blink_phase.
  - While blink_phase=1, each digit with blink_mask[i]=1 is fully off: its seg slice is 7'h7F and punto[i]=1.
- Digit blanking overrides dp only under blink; otherwise punto[i] = ~dp_q[i].
- All inputs other than clk and rst are synchronous to clk; no CDC is performed inside the block.

## Timing
- Reset (sync), at the first rising edge with rst=1:
  - value_q=0, dp_q=0.
  - Counter=0, blink_phase=0.
  - seg = all 1, punto = all 1 (display dark).
  - Reset mid-blink or mid-shift discards all state. The first post-reset cycle shows all zeros, subject to lz_blank.
- Latency:
  - wr_en/shift_en sampled at edge k → value_q updated at edge k; seg/punto reflect it after edge k+1 (2-edge latency, registered outputs, glitch-free pins).
  - lz_blank and blink_mask are combinational into the output registers: 1-edge latency.
- blink_phase toggles on the edge where the counter is at BLINK_DIV-1. Period = 2*BLINK_DIV cycles, 50% duty.
- Back-to-back shift_en on consecutive cycles is legal: one digit per cycle, with no stall and no ready signal.
- Outputs stay stable between events; no output changes except on rising clk edges.

## Test plan
- Reset: assert rst for 2 cycles, then wr_en=0, lz_blank=0 → seg = 8×7'h40 ("0" inverted), punto = 8'hFF; during rst seg = all 1.
- Parallel load: wr_data=32'h0123ABCD, wr_dp=8'h10, lz_blank=1 → digit7 blank (7'h7F), digit6 = ~06, digit0 = ~5E, punto=8'hEF, appearing 2 edges after wr_en.
- Shift: from 0, shift in 1,2,3 on consecutive cycles → value_q=32'h00000123; with lz_blank=1 digits 3..7 blank, digit2 = ~06; a simultaneous wr_en=1 with wr_data=32'hFFFFFFFF on the 3rd cycle → value_q=32'hFFFFFFFF.
- Blink (BLINK_DIV=4): blink_mask=8'h01, wr_dp=8'h01 → blink_phase toggles every 4 cycles; digit0 seg=7'h7F and punto[0]=1 for exactly 4 cycles out of 8; other digits steady.
- Zero with lz_blank: value 0, lz_blank=1 → digits 7..1 all 7'h7F, digit0 = 7'h40.
- Reset mid-blink: assert rst while blink_phase=1 → next edge blink_phase=0, counter restarts, first toggle occurs exactly BLINK_DIV cycles after rst deasserts.
